// File: rtl/adder_rr_scheduler_pkg.sv
// Shared types for the round-robin adder scheduler: tag entries that ride
// alongside each in-flight adder operation.
package adder_sched_pkg;
    localparam int DATA_W = 32;
    // Wide enough for the largest supported requester count (8).
    localparam int TAG_W  = 3;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } tag_entry_t;
endpackage

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index, and
// the pointer moves only when a grant is taken.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] elig,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + 1 + i) % N_REQ);
            if (!found && elig[cand]) begin
                found       = 1'b1;
                gnt[cand]   = 1'b1;
                gnt_idx     = cand;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance) last_d = gnt_idx;
    end

    // Reset to the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_q <= IDX_W'(N_REQ - 1);
        else       last_q <= last_d;
    end
endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one pipelined adder among N_REQ requesters: issue register, tag
// delay line, per-requester outstanding counters and the return register.
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 5,
    parameter int MAX_OUT = 3
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_a,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_b,
    input  logic [N_REQ-1:0]               req_cin,
    output logic [N_REQ-1:0]               gnt,
    output logic [DATA_W-1:0]              add_a,
    output logic [DATA_W-1:0]              add_b,
    output logic                           add_cin,
    output logic                           add_valid_in,
    input  logic [DATA_W-1:0]              add_s,
    input  logic                           add_cout,
    input  logic                           add_valid_out,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]              rsp_s,
    output logic                           rsp_cout,
    output logic                           busy,
    output logic                           err_orphan
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = 3;

    logic [N_REQ-1:0]               elig;
    logic [IDX_W-1:0]               gnt_idx;
    logic                           gnt_any;

    logic [DATA_W-1:0]              add_a_q, add_a_d, add_b_q, add_b_d;
    logic                           add_cin_q, add_cin_d;
    logic                           add_valid_in_q, add_valid_in_d;
    tag_entry_t [ADD_LAT:0]         tag_pipe_q, tag_pipe_d;
    tag_entry_t                     head;
    logic [N_REQ-1:0]               dec_q, dec_d;
    logic [N_REQ-1:0]               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]              rsp_s_q, rsp_s_d;
    logic                           rsp_cout_q, rsp_cout_d;
    logic                           err_orphan_q, err_orphan_d;
    logic [N_REQ-1:0][CNT_W-1:0]    out_cnt_q, out_cnt_d;

    // Registered counts gate eligibility; gating with rstn keeps gnt low in reset.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++)
            elig[i] = rstn && req[i] && (out_cnt_q[i] != CNT_W'(MAX_OUT));
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .elig    (elig),
        .advance (gnt_any),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_any = |gnt;
    // Entry 0 travels with add_valid_in; entry ADD_LAT lines up with add_valid_out.
    assign head    = tag_pipe_q[ADD_LAT];

    always_comb begin
        add_a_d        = add_a_q;
        add_b_d        = add_b_q;
        add_cin_d      = add_cin_q;
        add_valid_in_d = gnt_any;
        if (gnt_any) begin
            add_a_d   = req_a[gnt_idx];
            add_b_d   = req_b[gnt_idx];
            add_cin_d = req_cin[gnt_idx];
        end

        tag_pipe_d[0].valid = gnt_any;
        tag_pipe_d[0].tag   = tag_t'(gnt_idx);
        for (int k = 1; k <= ADD_LAT; k++)
            tag_pipe_d[k] = tag_pipe_q[k-1];
    end

    // A head tag retires its requester whether or not the adder delivered a result.
    always_comb begin
        dec_d = '0;
        for (int i = 0; i < N_REQ; i++)
            dec_d[i] = head.valid && (head.tag == tag_t'(i));
        rsp_valid_d  = add_valid_out ? dec_d : '0;
        rsp_s_d      = rsp_s_q;
        rsp_cout_d   = rsp_cout_q;
        if (add_valid_out && head.valid) begin
            rsp_s_d    = add_s;
            rsp_cout_d = add_cout;
        end
        err_orphan_d = err_orphan_q | (add_valid_out != head.valid);
    end

    // Decrement lands on the edge after the response, so the return cycle stays masked.
    always_comb begin
        out_cnt_d = out_cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i] && !(dec_q[i] && out_cnt_q[i] != '0))
                out_cnt_d[i] = out_cnt_q[i] + 1'b1;
            else if (!gnt[i] && dec_q[i] && out_cnt_q[i] != '0)
                out_cnt_d[i] = out_cnt_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            add_a_q        <= '0;
            add_b_q        <= '0;
            add_cin_q      <= 1'b0;
            add_valid_in_q <= 1'b0;
            tag_pipe_q     <= '0;
            dec_q          <= '0;
            rsp_valid_q    <= '0;
            rsp_s_q        <= '0;
            rsp_cout_q     <= 1'b0;
            err_orphan_q   <= 1'b0;
            out_cnt_q      <= '0;
        end else begin
            add_a_q        <= add_a_d;
            add_b_q        <= add_b_d;
            add_cin_q      <= add_cin_d;
            add_valid_in_q <= add_valid_in_d;
            tag_pipe_q     <= tag_pipe_d;
            dec_q          <= dec_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_s_q        <= rsp_s_d;
            rsp_cout_q     <= rsp_cout_d;
            err_orphan_q   <= err_orphan_d;
            out_cnt_q      <= out_cnt_d;
        end
    end

    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign add_cin      = add_cin_q;
    assign add_valid_in = add_valid_in_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_s        = rsp_s_q;
    assign rsp_cout     = rsp_cout_q;
    assign err_orphan   = err_orphan_q;
    assign busy         = |out_cnt_q;
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler with a behavioural 5-stage adder
// whose valid output can be forced to inject orphan results.
module tb_adder_rr_scheduler;
    localparam int N_REQ   = 4;
    localparam int ADD_LAT = 5;
    localparam int MAX_OUT = 3;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0][31:0]   req_a, req_b;
    logic [N_REQ-1:0]         req_cin;
    logic [N_REQ-1:0]         gnt;
    logic [31:0]              add_a, add_b, add_s;
    logic                     add_cin, add_valid_in, add_cout, add_valid_out;
    logic [N_REQ-1:0]         rsp_valid;
    logic [31:0]              rsp_s;
    logic                     rsp_cout, busy, err_orphan;
    logic                     force_vo;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    // Behavioural pipelined adder, reset by the same net.
    logic [ADD_LAT-1:0]       av_pipe;
    logic [ADD_LAT-1:0][32:0] ar_pipe;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            av_pipe <= '0;
            ar_pipe <= '0;
        end else begin
            av_pipe <= {av_pipe[ADD_LAT-2:0], add_valid_in};
            ar_pipe <= {ar_pipe[ADD_LAT-2:0], {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin}};
        end
    end
    assign add_valid_out = av_pipe[ADD_LAT-1] | force_vo;
    assign add_s         = ar_pipe[ADD_LAT-1][31:0];
    assign add_cout      = ar_pipe[ADD_LAT-1][32];

    adder_rr_scheduler #(.N_REQ(N_REQ), .ADD_LAT(ADD_LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_valid_in(add_valid_in),
        .add_s(add_s), .add_cout(add_cout), .add_valid_out(add_valid_out),
        .rsp_valid(rsp_valid), .rsp_s(rsp_s), .rsp_cout(rsp_cout), .busy(busy), .err_orphan(err_orphan)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; force_vo = 1'b0; rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req = '1; req_a = '1; req_b = '1; req_cin = '1; force_vo = 1'b0; rstn = 1'b0;
        #3;
        vec++; if (gnt !== 4'b0000) begin errs++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        tick();
        vec++; if ({add_valid_in, add_cin, add_a, add_b} !== 66'd0) begin errs++; $display("FAIL reset_issue: got v=%b a=%h b=%h cin=%b expected zeros", add_valid_in, add_a, add_b, add_cin); end
        vec++; if ({rsp_valid, rsp_s, rsp_cout} !== 37'd0) begin errs++; $display("FAIL reset_rsp: got v=%b s=%h c=%b expected zeros", rsp_valid, rsp_s, rsp_cout); end
        vec++; if ({busy, err_orphan} !== 2'b00) begin errs++; $display("FAIL reset_flags: got busy=%b err=%b expected 0 0", busy, err_orphan); end
        req = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'h1; req_cin[0] = 1'b0; req = 4'b0001;
        #1;
        vec++; if (gnt !== 4'b0001) begin errs++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        tick();
        req = '0;
        vec++; if (add_valid_in !== 1'b1 || add_a !== 32'hFFFF_FFFF || add_b !== 32'h1) begin errs++; $display("FAIL single_issue: got v=%b a=%h b=%h expected 1 ffffffff 00000001", add_valid_in, add_a, add_b); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b expected 1", busy); end
        for (int k = 1; k <= 7; k++) begin
            if (k < 7) begin
                vec++; if (rsp_valid !== 4'b0000) begin errs++; $display("FAIL single_early_rsp: cycle %0d got %b expected 0000", k, rsp_valid); end
                tick();
            end else begin
                vec++; if (rsp_valid !== 4'b0001 || rsp_s !== 32'h0 || rsp_cout !== 1'b1) begin errs++; $display("FAIL single_rsp: got v=%b s=%h c=%b expected 0001 00000000 1", rsp_valid, rsp_s, rsp_cout); end
            end
        end
        tick();
        vec++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errs++; $display("FAIL single_after: got v=%b busy=%b expected 0000 0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0][31:0] es;
        logic [N_REQ-1:0]       ec;
        logic [3:0]             eg;
        int                     g;
        do_reset();
        req_a[0] = 32'h0000_0010; req_b[0] = 32'h0000_0001; req_cin[0] = 1'b0;
        req_a[1] = 32'h0000_0020; req_b[1] = 32'h0000_0002; req_cin[1] = 1'b1;
        req_a[2] = 32'hFFFF_FFF0; req_b[2] = 32'h0000_0020; req_cin[2] = 1'b0;
        req_a[3] = 32'h7FFF_FFFF; req_b[3] = 32'h0000_0001; req_cin[3] = 1'b1;
        es[0] = 32'h0000_0011; ec[0] = 1'b0;
        es[1] = 32'h0000_0023; ec[1] = 1'b0;
        es[2] = 32'h0000_0010; ec[2] = 1'b1;
        es[3] = 32'h8000_0001; ec[3] = 1'b0;
        for (int c = 0; c < 16; c++) begin
            req = (c < 8) ? 4'hF : 4'h0;
            if (c >= 7 && c < 15) begin
                g = (c - 7) % 4;
                eg = 4'b0001 << g;
                vec++; if (rsp_valid !== eg || rsp_s !== es[g] || rsp_cout !== ec[g]) begin errs++; $display("FAIL rr_rsp: cycle %0d got v=%b s=%h c=%b expected %b %h %b", c, rsp_valid, rsp_s, rsp_cout, eg, es[g], ec[g]); end
            end else begin
                vec++; if (rsp_valid !== 4'b0000) begin errs++; $display("FAIL rr_idle_rsp: cycle %0d got %b expected 0000", c, rsp_valid); end
            end
            #1;
            eg = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            vec++; if (gnt !== eg) begin errs++; $display("FAIL rr_gnt: cycle %0d got %b expected %b", c, gnt, eg); end
            tick();
        end
    endtask

    task automatic test_cap();
        logic [11:0] pat;
        logic [3:0]  eg;
        pat = 12'b0111_0000_0111;
        do_reset();
        req_a[1] = 32'd5; req_b[1] = 32'd6; req_cin[1] = 1'b0; req = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            if (c >= 7 && c <= 9) begin
                vec++; if (rsp_valid !== 4'b0010 || rsp_s !== 32'd11) begin errs++; $display("FAIL cap_rsp: cycle %0d got v=%b s=%h expected 0010 0000000b", c, rsp_valid, rsp_s); end
            end
            #1;
            eg = pat[c] ? 4'b0010 : 4'b0000;
            vec++; if (gnt !== eg) begin errs++; $display("FAIL cap_gnt: cycle %0d got %b expected %b", c, gnt, eg); end
            tick();
        end
        req = '0;
        for (int c = 0; c < 10; c++) tick();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL cap_drain_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mixed();
        logic [3:0] eg;
        do_reset();
        req_a[2] = 32'h1234_5678; req_b[2] = 32'h0FED_CBA9; req_cin[2] = 1'b1;
        req_a[3] = 32'h8000_0000; req_b[3] = 32'h8000_0000; req_cin[3] = 1'b0;
        for (int c = 0; c < 11; c++) begin
            req = (c < 4) ? 4'b1100 : 4'b0000;
            if (c >= 7) begin
                if (c[0]) begin
                    vec++; if (rsp_valid !== 4'b0100 || rsp_s !== 32'h2222_2222 || rsp_cout !== 1'b0) begin errs++; $display("FAIL mixed_rsp2: cycle %0d got v=%b s=%h c=%b expected 0100 22222222 0", c, rsp_valid, rsp_s, rsp_cout); end
                end else begin
                    vec++; if (rsp_valid !== 4'b1000 || rsp_s !== 32'h0 || rsp_cout !== 1'b1) begin errs++; $display("FAIL mixed_rsp3: cycle %0d got v=%b s=%h c=%b expected 1000 00000000 1", c, rsp_valid, rsp_s, rsp_cout); end
                end
            end
            #1;
            eg = (c >= 4) ? 4'b0000 : (c[0] ? 4'b1000 : 4'b0100);
            vec++; if (gnt !== eg) begin errs++; $display("FAIL mixed_gnt: cycle %0d got %b expected %b", c, gnt, eg); end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        do_reset();
        req_a[0] = 32'd1; req_b[0] = 32'd2; req_cin[0] = 1'b0; req = 4'b0001;
        tick();
        req = '0;
        for (int c = 0; c < 6; c++) tick();
        vec++; if (rsp_valid !== 4'b0001 || rsp_s !== 32'd3) begin errs++; $display("FAIL mid_pre_rsp: got v=%b s=%h expected 0001 00000003", rsp_valid, rsp_s); end
        tick();
        req = 4'hF;
        for (int c = 0; c < 4; c++) tick();
        vec++; if (busy !== 1'b1 || add_valid_in !== 1'b1) begin errs++; $display("FAIL mid_inflight: got busy=%b vin=%b expected 1 1", busy, add_valid_in); end
        #2;
        rstn = 1'b0;
        #1;
        vec++; if (gnt !== 4'b0000) begin errs++; $display("FAIL mid_gnt: got %b expected 0000", gnt); end
        vec++; if ({add_valid_in, add_cin, add_a, add_b} !== 66'd0) begin errs++; $display("FAIL mid_issue: got v=%b a=%h b=%h cin=%b expected zeros", add_valid_in, add_a, add_b, add_cin); end
        vec++; if ({rsp_valid, rsp_s, rsp_cout, busy, err_orphan} !== 39'd0) begin errs++; $display("FAIL mid_rsp: got v=%b s=%h c=%b busy=%b err=%b expected zeros", rsp_valid, rsp_s, rsp_cout, busy, err_orphan); end
        tick();
        req = '0;
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rsp_valid !== 4'b0000 || err_orphan !== 1'b0) seen++;
        end
        vec++; if (seen != 0) begin errs++; $display("FAIL mid_after: got %0d cycles with rsp/err activity expected 0", seen); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b expected 0", busy); end
    endtask

    task automatic test_orphan();
        do_reset();
        tick();
        vec++; if (err_orphan !== 1'b0) begin errs++; $display("FAIL orphan_pre: got %b expected 0", err_orphan); end
        force_vo = 1'b1;
        tick();
        force_vo = 1'b0;
        vec++; if (err_orphan !== 1'b1) begin errs++; $display("FAIL orphan_set: got %b expected 1", err_orphan); end
        vec++; if (rsp_valid !== 4'b0000) begin errs++; $display("FAIL orphan_rsp: got %b expected 0000", rsp_valid); end
        for (int c = 0; c < 5; c++) tick();
        vec++; if (err_orphan !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL orphan_sticky: got err=%b busy=%b expected 1 0", err_orphan, busy); end
        rstn = 1'b0;
        #1;
        vec++; if (err_orphan !== 1'b0) begin errs++; $display("FAIL orphan_clear: got %b expected 0", err_orphan); end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_cap();
        test_mixed();
        test_reset_midflight();
        test_orphan();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
